mac_array_ctrl: RTL and testbench

MAC_ARRAY_CTRL -- requirements
Module: mac_array_ctrl

---
 rtl/mac_array_ctrl_pkg.sv | 20 ++
 rtl/mac_array_ctrl_if.sv | 31 +++
 rtl/mac_array_ctrl.sv | 158 +++++++++++++++
 tb/tb_mac_array_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mac_array_ctrl_pkg.sv
// rtl/mac_array_ctrl_pkg.sv - shared state encoding and array instruction codes
//
// Purpose : FSM state type and inst_w encodings used by mac_array_ctrl.
// Ports   : none (package).
package mac_array_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_GAP   = 3'd2,
    S_EXEC  = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [1:0] INST_IDLE = 2'b00;
  localparam logic [1:0] INST_LOAD = 2'b01;
  localparam logic [1:0] INST_EXEC = 2'b10;

endpackage

// File: rtl/mac_array_ctrl_if.sv
// rtl/mac_array_ctrl_if.sv - job request / array instruction bundle for mac_array_ctrl
//
// Purpose : groups the job handshake, L0 status and array instruction signals.
// Modports: master - job requester / L0 side (drives start, skip_load, num_vec, l0_empty)
//           slave  - controller (drives inst_w, l0_rd, busy, done[, stall_cnt])
// Config  : MAC_ARRAY_CTRL_STALL_CNT_EN adds the 16-bit stall_cnt signal.
interface mac_array_ctrl_if #(
  parameter int len_bw = 8
);
  logic              start;
  logic              skip_load;
  logic [len_bw-1:0] num_vec;
  logic              l0_empty;
  logic [1:0]        inst_w;
  logic              l0_rd;
  logic              busy;
  logic              done;
`ifdef MAC_ARRAY_CTRL_STALL_CNT_EN
  logic [15:0]       stall_cnt;

  modport master (output start, skip_load, num_vec, l0_empty,
                  input  inst_w, l0_rd, busy, done, stall_cnt);
  modport slave  (input  start, skip_load, num_vec, l0_empty,
                  output inst_w, l0_rd, busy, done, stall_cnt);
`else
  modport master (output start, skip_load, num_vec, l0_empty,
                  input  inst_w, l0_rd, busy, done);
  modport slave  (input  start, skip_load, num_vec, l0_empty,
                  output inst_w, l0_rd, busy, done);
`endif
endinterface

// File: rtl/mac_array_ctrl.sv
// rtl/mac_array_ctrl.sv - systolic MAC array job sequencer (load, gap, exec, drain)
//
// Purpose : sequences one array job per accepted start: col kernel-load issues,
//           col-cycle gap, num_vec execute issues, row+col drain, one-cycle done.
// Ports   : clk   - rising-edge clock
//           reset - asynchronous active-high reset
//           bus   - mac_array_ctrl_if.slave (start/skip_load/num_vec/l0_empty in,
//                   inst_w/l0_rd/busy/done[/stall_cnt] out)
// Config  : MAC_ARRAY_CTRL_STALL_CNT_EN enables the saturating stall_cnt counter.
module mac_array_ctrl
  import mac_array_ctrl_pkg::*;
#(
  parameter int row    = 8,
  parameter int col    = 8,
  parameter int len_bw = 8
) (
  input  logic            clk,
  input  logic            reset,
  mac_array_ctrl_if.slave bus
);

  localparam int unsigned COL_LAST_I   = col - 1;
  localparam int unsigned DRAIN_LAST_I = row + col - 1;
  localparam logic [len_bw-1:0] col_last   = COL_LAST_I[len_bw-1:0];
  localparam logic [len_bw-1:0] drain_last = DRAIN_LAST_I[len_bw-1:0];

  state_t            state_q, state_d;
  logic [len_bw-1:0] cnt_q, cnt_d;
  logic [len_bw-1:0] num_vec_q, num_vec_d;
  logic              skip_q, skip_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
`ifdef MAC_ARRAY_CTRL_STALL_CNT_EN
  logic [15:0]       stall_cnt_q, stall_cnt_d;
`endif

  logic issue_load;
  logic issue_exec;
  logic stall;

  // An issue cycle only happens when L0 has data; otherwise the slot is a stall
  // and the counter holds. A skip job never enters LOAD, so skip_q gates it too.
  assign issue_load = (state_q == S_LOAD) && !skip_q && !bus.l0_empty;
  assign issue_exec = (state_q == S_EXEC) && !bus.l0_empty;
  assign stall      = ((state_q == S_LOAD) || (state_q == S_EXEC)) && bus.l0_empty;

  assign bus.inst_w = issue_load ? INST_LOAD : (issue_exec ? INST_EXEC : INST_IDLE);
  assign bus.l0_rd  = issue_load || issue_exec;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
`ifdef MAC_ARRAY_CTRL_STALL_CNT_EN
  assign bus.stall_cnt = stall_cnt_q;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    num_vec_d = num_vec_q;
    skip_d    = skip_q;
`ifdef MAC_ARRAY_CTRL_STALL_CNT_EN
    stall_cnt_d = stall_cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          num_vec_d = bus.num_vec;
          skip_d    = bus.skip_load;
          cnt_d     = '0;
`ifdef MAC_ARRAY_CTRL_STALL_CNT_EN
          stall_cnt_d = '0;
`endif
          if (!bus.skip_load)           state_d = S_LOAD;
          else if (bus.num_vec == '0)   state_d = S_DRAIN;
          else                          state_d = S_EXEC;
        end
      end
      S_LOAD: begin
        if (issue_load) begin
          if (cnt_q == col_last) begin
            cnt_d   = '0;
            state_d = (num_vec_q == '0) ? S_DRAIN : S_GAP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_GAP: begin
        if (cnt_q == col_last) begin
          cnt_d   = '0;
          state_d = S_EXEC;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_EXEC: begin
        // Compare against num_vec-1 so the all-ones vector count finishes
        // before the counter could wrap.
        if (issue_exec) begin
          if (cnt_q == num_vec_q - 1'b1) begin
            cnt_d   = '0;
            state_d = S_DRAIN;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (cnt_q == drain_last) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

`ifdef MAC_ARRAY_CTRL_STALL_CNT_EN
    if (stall && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
`endif

    // busy/done are registered off the next state so they line up with state_q.
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      num_vec_q <= '0;
      skip_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef MAC_ARRAY_CTRL_STALL_CNT_EN
      stall_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      num_vec_q <= num_vec_d;
      skip_q    <= skip_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef MAC_ARRAY_CTRL_STALL_CNT_EN
      stall_cnt_q <= stall_cnt_d;
`endif
    end
  end

`ifndef MAC_ARRAY_CTRL_STALL_CNT_EN
  logic unused_stall;
  assign unused_stall = stall;
`endif

endmodule

// File: tb/tb_mac_array_ctrl.sv
// tb/tb_mac_array_ctrl.sv - randomized self-checking bench for mac_array_ctrl
module tb_mac_array_ctrl;

  localparam int ROW    = 8;
  localparam int COL    = 8;
  localparam int LEN_BW = 8;

  localparam int K_LOAD  = 0;
  localparam int K_WAIT  = 1;
  localparam int K_EXEC  = 2;
  localparam int K_DRAIN = 3;
  localparam int K_DONE  = 4;

  typedef struct {
    int kind;
    int left;
  } phase_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mac_array_ctrl_if #(.len_bw(LEN_BW)) bus ();

  mac_array_ctrl #(.row(ROW), .col(COL), .len_bw(LEN_BW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit empty_for(input int c, input int pct, input int force_from);
    if (c >= force_from && c < force_from + 5) return 1'b1;
    return ($urandom_range(99) < pct);
  endfunction

  // One job: the model is an ordered list of phases derived from the job rules;
  // stallable phases consume an issue only on cycles where L0 has data.
  task automatic run_job(input bit skip, input int n, input int pct,
                         input bit repulse, input int force_from);
    phase_t ph[$];
    phase_t p;
    int cyc, lat, exp_stall, e_inst, e_rd, e_done, issues_exp;
    bit pulsed, in_drain;
    ph.delete();
    if (!skip) ph.push_back('{K_LOAD, COL});
    if (n > 0) begin
      if (!skip) ph.push_back('{K_WAIT, COL});
      ph.push_back('{K_EXEC, n});
    end
    ph.push_back('{K_DRAIN, ROW + COL});
    ph.push_back('{K_DONE, 1});
    issues_exp = (skip ? 0 : COL) + n;

    @(negedge clk);
    bus.start     = 1'b1;
    bus.skip_load = skip;
    bus.num_vec   = LEN_BW'(n);
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
    bus.l0_empty = empty_for(1, pct, force_from);
    cyc = 0; lat = 0; exp_stall = 0; pulsed = 1'b0;

    while (ph.size() > 0 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      p = ph[0];
      e_inst = 0; e_rd = 0; e_done = 0;
      case (p.kind)
        K_LOAD, K_EXEC: begin
          if (!bus.l0_empty) begin
            e_inst = (p.kind == K_LOAD) ? 1 : 2;
            e_rd   = 1;
            p.left--;
          end else begin
            exp_stall++;
          end
        end
        K_DONE: begin
          e_done = 1;
          lat    = cyc;
          p.left--;
        end
        default: p.left--;
      endcase
      check("inst_w", int'(bus.inst_w), e_inst);
      check("l0_rd", int'(bus.l0_rd), e_rd);
      check("done", int'(bus.done), e_done);
      check("busy", int'(bus.busy), 1);
      if (p.left == 0) void'(ph.pop_front());
      else ph[0] = p;
      in_drain = (ph.size() > 0) && (ph[0].kind == K_DRAIN) && (ph[0].left > 2);
      @(posedge clk);
      #1;
      bus.l0_empty = empty_for(cyc + 1, pct, force_from);
      if (repulse && in_drain && !pulsed) begin
        bus.start     = 1'b1;
        bus.skip_load = ~skip;
        bus.num_vec   = 8'd7;
        pulsed        = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    if (ph.size() != 0) check("job_timeout", ph.size(), 0);

    check("latency", lat, 1 + (skip ? 0 : COL) + ((n > 0) ? ((skip ? 0 : COL) + n) : 0)
                          + ROW + COL + exp_stall);
    if (!skip && n > 0 && pct == 0 && force_from < 0)
      check("latency_formula", lat, 1 + 2 * COL + n + ROW + COL);
    if (issues_exp >= 0 && skip && n == 3 && pct == 0)
      check("skip_latency", lat, 1 + 3 + ROW + COL);

    // Cycle after DONE: back to IDLE.
    @(negedge clk);
    check("busy_after", int'(bus.busy), 0);
    check("done_after", int'(bus.done), 0);
    check("inst_after", int'(bus.inst_w), 0);
`ifdef MAC_ARRAY_CTRL_STALL_CNT_EN
    check("stall_cnt", int'(bus.stall_cnt), exp_stall);
`endif
    if (repulse) begin
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        check("no_second_done", int'(bus.done), 0);
        check("idle_busy", int'(bus.busy), 0);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.skip_load = 1'b0;
    bus.num_vec   = '0;
    bus.l0_empty  = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_inst_w", int'(bus.inst_w), 0);
    check("rst_l0_rd", int'(bus.l0_rd), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
`ifdef MAC_ARRAY_CTRL_STALL_CNT_EN
    check("rst_stall_cnt", int'(bus.stall_cnt), 0);
`endif
    reset = 1'b0;

    run_job(1'b0, 4, 0, 1'b0, -100);
    run_job(1'b1, 3, 0, 1'b0, -100);
    run_job(1'b0, 0, 0, 1'b0, -100);
    run_job(1'b0, 6, 0, 1'b0, 18);
    run_job(1'b0, 5, 0, 1'b1, -100);
    run_job(1'b1, 0, 0, 1'b0, -100);

    // Reset in the middle of EXEC: outputs drop at once, no done follows.
    @(negedge clk);
    bus.start     = 1'b1;
    bus.skip_load = 1'b0;
    bus.num_vec   = 8'd10;
    bus.l0_empty  = 1'b0;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (19) @(negedge clk);
    check("pre_reset_exec", int'(bus.inst_w), 2);
    #1 reset = 1'b1;
    #1;
    check("mid_rst_inst_w", int'(bus.inst_w), 0);
    check("mid_rst_l0_rd", int'(bus.l0_rd), 0);
    check("mid_rst_busy", int'(bus.busy), 0);
    check("mid_rst_done", int'(bus.done), 0);
`ifdef MAC_ARRAY_CTRL_STALL_CNT_EN
    check("mid_rst_stall_cnt", int'(bus.stall_cnt), 0);
`endif
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      check("post_rst_done", int'(bus.done), 0);
    end
    run_job(1'b0, 10, 0, 1'b0, -100);

    run_job(1'b0, 255, 10, 1'b0, -100);

    for (int j = 0; j < 12; j++) begin
      run_job(1'($urandom_range(1)), int'($urandom_range(20)),
              int'($urandom_range(40)), 1'($urandom_range(1)), -100);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
